// File: rtl/scd_diag_reader_pkg.sv
// Shared types and constants for the SCD diagnostic-read initiator.
package scd_diag_pkg;

    localparam int EBUS_W = 36;
    localparam int DIAG_W = 3;

    localparam logic [DIAG_W-1:0] DIAG_GRP_LAST = 3'd7;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_DRIVE   = 3'd1,
        ST_PRESENT = 3'd2,
        ST_GAP     = 3'd3,
        ST_FIN     = 3'd4
    } state_e;

endpackage

// File: rtl/scd_diag_reader_if.sv
// Request, SCD-side (DIAG/EBUS) and consumer-side signals of the diagnostic reader.
interface scd_diag_reader_if
    import scd_diag_pkg::*;
    ;

    logic                REQ;
    logic                REQ_SWEEP;
    logic [DIAG_W-1:0]   REQ_SEL;
    logic                BUSY;
    logic [4:6]          DIAG;
    logic                DIAG_READ_FUNC_13X;
    logic [0:EBUS_W-1]   EBUS;
    logic                RD_VALID;
    logic                RD_READY;
    logic [DIAG_W-1:0]   RD_SEL;
    logic [0:EBUS_W-1]   RD_DATA;
    logic                DONE;

    modport master (
        input  REQ, REQ_SWEEP, REQ_SEL, EBUS, RD_READY,
        output BUSY, DIAG, DIAG_READ_FUNC_13X, RD_VALID, RD_SEL, RD_DATA, DONE
    );

    modport slave (
        output REQ, REQ_SWEEP, REQ_SEL, EBUS, RD_READY,
        input  BUSY, DIAG, DIAG_READ_FUNC_13X, RD_VALID, RD_SEL, RD_DATA, DONE
    );

endinterface

// File: rtl/scd_diag_reader.sv
// SCD diagnostic-read initiator: strobes one group (or sweeps 0..7), waits for
// EBUS to settle, captures the word and hands it to the consumer via valid/ready.
module scd_diag_reader
    import scd_diag_pkg::*;
#(
    parameter int SETTLE_CYCLES = 2
) (
    input  logic              clk,
    input  logic              RESET_N,
    scd_diag_reader_if.master bus
);

    if (SETTLE_CYCLES < 1 || SETTLE_CYCLES > 15) begin : g_bad_settle
        $error("SETTLE_CYCLES must be in 1..15");
    end

    localparam logic [3:0] SETTLE_LAST = 4'(SETTLE_CYCLES - 1);

    state_e              state_q, state_d;
    logic [3:0]          cnt_q, cnt_d;
    logic [DIAG_W-1:0]   grp_q, grp_d;
    logic                sweep_q, sweep_d;
    logic [EBUS_W-1:0]   rd_data_q, rd_data_d;
    logic [DIAG_W-1:0]   rd_sel_q, rd_sel_d;
    logic                busy_q, busy_d;
    logic [DIAG_W-1:0]   diag_q, diag_d;
    logic                strb_q, strb_d;
    logic                vld_q, vld_d;
    logic                done_q, done_d;

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        grp_d     = grp_q;
        sweep_d   = sweep_q;
        rd_data_d = rd_data_q;
        rd_sel_d  = rd_sel_q;

        case (state_q)
            ST_IDLE: begin
                if (bus.REQ) begin
                    sweep_d = bus.REQ_SWEEP;
                    grp_d   = bus.REQ_SWEEP ? '0 : bus.REQ_SEL;
                    cnt_d   = '0;
                    state_d = ST_DRIVE;
                end
            end
            ST_DRIVE: begin
                if (cnt_q == SETTLE_LAST) begin
                    rd_data_d = bus.EBUS;
                    rd_sel_d  = grp_q;
                    cnt_d     = '0;
                    state_d   = ST_PRESENT;
                end else begin
                    cnt_d = cnt_q + 4'd1;
                end
            end
            ST_PRESENT: begin
                // RD_VALID is high throughout PRESENT, so READY alone marks a transfer.
                if (bus.RD_READY) begin
                    if (sweep_q && (grp_q != DIAG_GRP_LAST)) begin
                        grp_d   = grp_q + 3'd1;
                        state_d = ST_GAP;
                    end else begin
                        state_d = ST_FIN;
                    end
                end
            end
            ST_GAP: begin
                cnt_d   = '0;
                state_d = ST_DRIVE;
            end
            ST_FIN: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Outputs are decoded from the next state so they leave flops directly.
        busy_d = (state_d != ST_IDLE);
        strb_d = (state_d == ST_DRIVE);
        diag_d = strb_d ? grp_d : '0;
        vld_d  = (state_d == ST_PRESENT);
        done_d = (state_d == ST_FIN);
    end

    always_ff @(posedge clk) begin
        if (!RESET_N) begin
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            grp_q     <= '0;
            sweep_q   <= 1'b0;
            rd_data_q <= '0;
            rd_sel_q  <= '0;
            busy_q    <= 1'b0;
            diag_q    <= '0;
            strb_q    <= 1'b0;
            vld_q     <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            grp_q     <= grp_d;
            sweep_q   <= sweep_d;
            rd_data_q <= rd_data_d;
            rd_sel_q  <= rd_sel_d;
            busy_q    <= busy_d;
            diag_q    <= diag_d;
            strb_q    <= strb_d;
            vld_q     <= vld_d;
            done_q    <= done_d;
        end
    end

    assign bus.BUSY               = busy_q;
    assign bus.DIAG               = diag_q;
    assign bus.DIAG_READ_FUNC_13X = strb_q;
    assign bus.RD_VALID           = vld_q;
    assign bus.RD_SEL             = rd_sel_q;
    assign bus.RD_DATA            = rd_data_q;
    assign bus.DONE               = done_q;

endmodule

// File: tb/tb_scd_diag_reader.sv
// Scoreboard bench for scd_diag_reader (SETTLE_CYCLES=2 main instance, =1 latency instance).
module tb_scd_diag_reader;
    import scd_diag_pkg::*;

    logic clk = 1'b0;
    logic RESET_N;
    always #5 clk = ~clk;

    scd_diag_reader_if a_if ();
    scd_diag_reader_if b_if ();

    scd_diag_reader #(.SETTLE_CYCLES(2)) dut_a (.clk(clk), .RESET_N(RESET_N), .bus(a_if.master));
    scd_diag_reader #(.SETTLE_CYCLES(1)) dut_b (.clk(clk), .RESET_N(RESET_N), .bus(b_if.master));

    typedef struct packed {
        logic [2:0]  sel;
        logic [35:0] data;
    } exp_t;

    exp_t q[$];
    int   total = 0;
    int   bad   = 0;
    int   done_a = 0;

    logic        pat_mode;
    logic [35:0] ebus_val;

    function automatic logic [35:0] pat(input logic [2:0] g);
        case (g)
            3'd0: return 36'o000000000000;
            3'd1: return 36'o111111111111;
            3'd2: return 36'o222222222222;
            3'd3: return 36'o333333333333;
            3'd4: return 36'o444444444444;
            3'd5: return 36'o555555555555;
            3'd6: return 36'o666666666666;
            default: return 36'o777777777777;
        endcase
    endfunction

    // SCD model: in pattern mode the bus reflects whichever group DIAG selects.
    always_comb a_if.EBUS = pat_mode ? pat(a_if.DIAG) : ebus_val;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic start_a(input logic sweep, input logic [2:0] sel);
        a_if.REQ       = 1'b1;
        a_if.REQ_SWEEP = sweep;
        a_if.REQ_SEL   = sel;
        step();
        a_if.REQ       = 1'b0;
    endtask

    always @(negedge clk) begin
        if (RESET_N && a_if.RD_VALID && a_if.RD_READY) begin
            chk("sb_word_expected", 64'(q.size() != 0), 64'd1);
            if (q.size() != 0) begin
                exp_t e;
                e = q.pop_front();
                chk("sb_rd_sel", 64'(a_if.RD_SEL), 64'(e.sel));
                chk("sb_rd_data", 64'(a_if.RD_DATA), 64'(e.data));
            end
        end
        if (RESET_N && a_if.DONE) done_a++;
    end

    initial begin
        int d0, w, cyc, hi, vl, gp, dn, bz;
        RESET_N        = 1'b0;
        pat_mode       = 1'b0;
        ebus_val       = '0;
        a_if.REQ       = 1'b0;
        a_if.REQ_SWEEP = 1'b0;
        a_if.REQ_SEL   = '0;
        a_if.RD_READY  = 1'b0;
        b_if.REQ       = 1'b0;
        b_if.REQ_SWEEP = 1'b0;
        b_if.REQ_SEL   = '0;
        b_if.RD_READY  = 1'b0;
        b_if.EBUS      = '0;
        repeat (3) step();
        chk("reset_outs_a", 64'({a_if.BUSY, a_if.DIAG, a_if.DIAG_READ_FUNC_13X, a_if.RD_VALID,
                                 a_if.RD_SEL, a_if.RD_DATA, a_if.DONE}), 64'd0);
        chk("reset_outs_b", 64'({b_if.BUSY, b_if.DIAG, b_if.DIAG_READ_FUNC_13X, b_if.RD_VALID,
                                 b_if.RD_SEL, b_if.RD_DATA, b_if.DONE}), 64'd0);
        RESET_N = 1'b1;
        step();

        // single read, group 5
        ebus_val      = 36'o123456701234;
        a_if.RD_READY = 1'b1;
        q.push_back('{sel: 3'd5, data: 36'o123456701234});
        start_a(1'b0, 3'd5);
        chk("t1_c1_diag", 64'(a_if.DIAG), 64'd5);
        chk("t1_c1_strobe", 64'(a_if.DIAG_READ_FUNC_13X), 64'd1);
        chk("t1_c1_busy", 64'(a_if.BUSY), 64'd1);
        step();
        chk("t1_c2_diag", 64'(a_if.DIAG), 64'd5);
        chk("t1_c2_strobe", 64'(a_if.DIAG_READ_FUNC_13X), 64'd1);
        chk("t1_c2_valid", 64'(a_if.RD_VALID), 64'd0);
        step();
        chk("t1_c3_valid", 64'(a_if.RD_VALID), 64'd1);
        chk("t1_c3_strobe_diag", 64'({a_if.DIAG_READ_FUNC_13X, a_if.DIAG}), 64'd0);
        chk("t1_c3_sel", 64'(a_if.RD_SEL), 64'd5);
        chk("t1_c3_data", 64'(a_if.RD_DATA), 64'(36'o123456701234));
        step();
        chk("t1_c4_done", 64'(a_if.DONE), 64'd1);
        chk("t1_c4_valid", 64'(a_if.RD_VALID), 64'd0);
        chk("t1_c4_busy", 64'(a_if.BUSY), 64'd1);
        step();
        chk("t1_c5_busy", 64'(a_if.BUSY), 64'd0);
        chk("t1_c5_done", 64'(a_if.DONE), 64'd0);

        // full sweep; REQ_SEL must be ignored
        pat_mode = 1'b1;
        for (int g = 0; g < 8; g++) q.push_back('{sel: 3'(g), data: pat(3'(g))});
        d0 = done_a;
        start_a(1'b1, 3'd5);
        cyc = 0; hi = 0; vl = 0; gp = 0; dn = 0;
        while (a_if.BUSY && cyc < 100) begin
            if (a_if.DIAG_READ_FUNC_13X) hi++;
            if (a_if.RD_VALID) vl++;
            if (a_if.DONE) dn++;
            if (!a_if.DIAG_READ_FUNC_13X && !a_if.RD_VALID && !a_if.DONE) gp++;
            step();
            cyc++;
        end
        chk("sw_busy_cycles", 64'(cyc), 64'd32);
        chk("sw_strobe_cycles", 64'(hi), 64'd16);
        chk("sw_valid_cycles", 64'(vl), 64'd8);
        chk("sw_gap_cycles", 64'(gp), 64'd7);
        chk("sw_done_pulses", 64'(dn), 64'd1);
        chk("sw_done_mon", 64'(done_a - d0), 64'd1);
        chk("sw_queue_drained", 64'(q.size()), 64'd0);

        // backpressure: word and select must hold while EBUS moves
        pat_mode      = 1'b0;
        ebus_val      = 36'o246013572460;
        a_if.RD_READY = 1'b0;
        q.push_back('{sel: 3'd3, data: 36'o246013572460});
        start_a(1'b0, 3'd3);
        w = 0;
        while (!a_if.RD_VALID && w < 20) begin step(); w++; end
        chk("bp_reach_valid", 64'(a_if.RD_VALID), 64'd1);
        ebus_val = 36'o777777777777;
        for (int i = 0; i < 10; i++) begin
            chk("bp_valid", 64'(a_if.RD_VALID), 64'd1);
            chk("bp_data", 64'(a_if.RD_DATA), 64'(36'o246013572460));
            chk("bp_sel", 64'(a_if.RD_SEL), 64'd3);
            chk("bp_strobe", 64'(a_if.DIAG_READ_FUNC_13X), 64'd0);
            step();
        end
        a_if.RD_READY = 1'b1;
        step();
        chk("bp_done", 64'(a_if.DONE), 64'd1);
        step();
        chk("bp_idle", 64'(a_if.BUSY), 64'd0);

        // REQ held high through the whole read, FIN cycle included
        ebus_val = 36'o000011112222;
        q.push_back('{sel: 3'd6, data: 36'o000011112222});
        d0 = done_a;
        a_if.REQ = 1'b1; a_if.REQ_SWEEP = 1'b0; a_if.REQ_SEL = 3'd6;
        step();
        a_if.REQ_SWEEP = 1'b1; a_if.REQ_SEL = 3'd1;
        w = 0;
        while (!a_if.DONE && w < 20) begin step(); w++; end
        chk("rq_done_seen", 64'(a_if.DONE), 64'd1);
        step();
        a_if.REQ = 1'b0;
        chk("rq_idle_after_fin", 64'(a_if.BUSY), 64'd0);
        bz = 0;
        for (int i = 0; i < 8; i++) begin
            step();
            if (a_if.BUSY) bz++;
        end
        chk("rq_no_extra_read", 64'(bz), 64'd0);
        chk("rq_one_done", 64'(done_a - d0), 64'd1);

        // reset during DRIVE of group 3 of a sweep
        pat_mode = 1'b1;
        for (int g = 0; g < 8; g++) q.push_back('{sel: 3'(g), data: pat(3'(g))});
        d0 = done_a;
        start_a(1'b1, 3'd0);
        w = 0;
        while (!(a_if.DIAG_READ_FUNC_13X && a_if.DIAG == 3'd3) && w < 60) begin step(); w++; end
        chk("rst_reach_grp3", 64'({a_if.DIAG_READ_FUNC_13X, a_if.DIAG}), 64'({1'b1, 3'd3}));
        RESET_N = 1'b0;
        step();
        RESET_N = 1'b1;
        chk("rst_outs_zero", 64'({a_if.BUSY, a_if.DIAG, a_if.DIAG_READ_FUNC_13X, a_if.RD_VALID,
                                  a_if.RD_SEL, a_if.RD_DATA, a_if.DONE}), 64'd0);
        chk("rst_pending_groups", 64'(q.size()), 64'd5);
        q.delete();
        step();
        chk("rst_no_done", 64'(done_a - d0), 64'd0);
        chk("rst_stays_idle", 64'(a_if.BUSY), 64'd0);
        q.push_back('{sel: 3'd2, data: 36'o222222222222});
        start_a(1'b0, 3'd2);
        w = 0;
        while (!a_if.DONE && w < 20) begin step(); w++; end
        chk("rst_new_read_done", 64'(a_if.DONE), 64'd1);
        step();
        chk("rst_new_read_drained", 64'(q.size()), 64'd0);

        // SETTLE_CYCLES=1 instance latency
        b_if.EBUS     = 36'o701234567012;
        b_if.RD_READY = 1'b1;
        b_if.REQ = 1'b1; b_if.REQ_SWEEP = 1'b0; b_if.REQ_SEL = 3'd4;
        step();
        b_if.REQ = 1'b0;
        chk("s1_c1_strobe_diag", 64'({b_if.DIAG_READ_FUNC_13X, b_if.DIAG}), 64'({1'b1, 3'd4}));
        chk("s1_c1_valid", 64'(b_if.RD_VALID), 64'd0);
        step();
        chk("s1_c2_valid", 64'(b_if.RD_VALID), 64'd1);
        chk("s1_c2_sel", 64'(b_if.RD_SEL), 64'd4);
        chk("s1_c2_data", 64'(b_if.RD_DATA), 64'(36'o701234567012));
        chk("s1_c2_strobe", 64'(b_if.DIAG_READ_FUNC_13X), 64'd0);
        step();
        chk("s1_c3_done", 64'(b_if.DONE), 64'd1);
        step();
        chk("s1_c4_busy", 64'(b_if.BUSY), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/scd_diag_reader.md
Name: scd_diag_reader

Overview:
- Initiator side of the SCD diagnostic-read path. It selects a read group on DIAG[4:6], asserts DIAG_READ_FUNC_13X, waits for the EBUS to settle, then captures the 36-bit EBUS word.
- Captured words are delivered to a console/diagnostic consumer over a valid/ready handshake.
- It does single-group reads, or a sweep of all eight groups (0..7) in order.
- It sits between the diagnostic controller and the EBUS that SCD drives.

Parameters:
- SETTLE_CYCLES, 2: number of cycles DIAG_READ_FUNC_13X is held high before EBUS is sampled. Legal range 1..15; an elaboration check rejects 0.

Ports:
- clk  input  1  system clock; all state changes on rising edge.
- RESET_N  input  1  synchronous, active-low reset.
- REQ  input  1  start request; sampled only in IDLE.
- REQ_SWEEP  input  1  1 = read groups 0..7; 0 = read group REQ_SEL only. Sampled with REQ.
- REQ_SEL  input  3  group for a single read. Sampled with REQ.
- BUSY  output  1  high from the cycle after REQ is accepted until the DONE cycle inclusive.
- DIAG  output  [4:6]  group select to SCD; 0 whenever DIAG_READ_FUNC_13X is low.
- DIAG_READ_FUNC_13X  output  1  diagnostic read-function strobe to SCD.
- EBUS  input  [0:35]  data driven by SCD.
- RD_VALID  output  1  captured word available.
- RD_READY  input  1  consumer accepts the word.
- RD_SEL  output  3  group of the presented word.
- RD_DATA  output  [0:35]  captured word; stable while RD_VALID is high.
- DONE  output  1  one-cycle pulse after the last word is transferred.

Behaviour:
- Reset (RESET_N low at an edge):
  - State goes to IDLE.
  - All outputs go to 0, including RD_DATA and RD_SEL.
  - Settle counter and group counter clear.
  - Reset mid-operation aborts immediately; no DONE is issued and the pending word is discarded.
- FSM states: IDLE, DRIVE, PRESENT, GAP, FIN.
- IDLE:
  - REQ=1 at edge latches mode and start group (REQ_SWEEP ? 0 : REQ_SEL) and moves to DRIVE.
  - REQ is ignored in every other state; no queueing.
- DRIVE:
  - DIAG = current group and DIAG_READ_FUNC_13X = 1, both registered outputs.
  - Stays for exactly SETTLE_CYCLES cycles, counted by the settle counter.
  - On the last DRIVE edge, EBUS is captured into RD_DATA and the group into RD_SEL, then the FSM moves to PRESENT.
  - Latency: the REQ edge is edge 0; capture occurs at edge SETTLE_CYCLES; RD_VALID is high from cycle SETTLE_CYCLES+1.
- PRESENT:
  - DIAG_READ_FUNC_13X = 0, DIAG = 0, RD_VALID = 1.
  - RD_DATA and RD_SEL are held unchanged until transfer (RD_VALID & RD_READY at an edge).
  - RD_READY may already be high on entry; the transfer then takes one cycle.
  - Indefinite stall is legal; there is no timeout.
- On transfer:
  - Sweep mode with group < 7: go to GAP, and the group increments.
  - Otherwise: go to FIN.
  - No wrap from 7 back to 0.
- GAP: one cycle with the strobe low, so the bus releases between groups; then DRIVE.
- FIN:
  - DONE = 1 and RD_VALID = 0 for one cycle, then IDLE.
  - A REQ in the FIN cycle is ignored.
  - BUSY drops in the IDLE cycle that follows.
- EBUS is sampled only at the capture edge; EBUS changes at other times have no effect.
- The group counter is 3 bits. Sweep termination compares against 7 explicitly; overflow is never relied on.

Decomposition:
- Shared package scd_diag_pkg holds:
  - FSM state enum.
  - Group constant DIAG_GRP_LAST=3'd7.
  - Width constants EBUS_W=36 and DIAG_W=3.
- No sub-module; settle counter, group counter and FSM live in one module.

Test Plan:
- Single read, SETTLE_CYCLES=2, REQ_SEL=5, EBUS=36'o123456701234, RD_READY=1:
  - DIAG=5 with strobe high for 2 cycles.
  - RD_VALID in cycle 3 with RD_SEL=5 and RD_DATA=36'o123456701234.
  - DONE in cycle 4; BUSY low in cycle 5.
- Sweep, EBUS = group-dependent pattern (group g drives 36'o0 + g*36'o111111111111), RD_READY=1:
  - Eight words with RD_SEL 0..7 in order.
  - Exactly one strobe-low GAP cycle between groups.
  - Single DONE pulse after group 7.
- Backpressure: RD_READY held 0 for 10 cycles while EBUS changes to 36'o777777777777:
  - RD_VALID, RD_DATA and RD_SEL stay stable.
  - Strobe stays low.
  - Transfer happens on the first RD_READY=1 edge.
- REQ pulsed repeatedly while BUSY, including the FIN cycle: no additional reads; exactly one DONE.
- RESET_N low in the middle of the sweep during DRIVE of group 3:
  - Next cycle all outputs are 0 and the FSM is in IDLE, with no DONE.
  - A new single REQ_SEL=2 read completes normally.
- SETTLE_CYCLES=1 build: capture at edge 1; RD_VALID in cycle 2.
